// File: rtl/fifo_pkg.sv
// Shared types and sizing for the simple_fifo read-side stream stage.
package fifo_pkg;
    localparam int FIFO_DATA_WIDTH = 8;
    localparam int OBUF_DEPTH      = 2;
    localparam int OCC_W           = 2;

    typedef logic [FIFO_DATA_WIDTH-1:0] fifo_data_t;
    typedef logic [OCC_W-1:0]           occ_t;
endpackage

// File: rtl/fifo_rd_obuf.sv
// Two-entry FIFO-ordered output buffer; entry 0 is always the head, so the
// stream payload comes straight from a register.
module fifo_rd_obuf import fifo_pkg::*; #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] head,
    output occ_t                  occ
);

    logic [DATA_WIDTH-1:0] entry_reg [OBUF_DEPTH];
    occ_t                  occ_reg;
    logic                  pop_ok;

    assign pop_ok = pop && (occ_reg != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
            occ_reg <= '0;
        end else if (clear) begin
            occ_reg <= '0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    entry_reg[occ_reg[0]] <= push_data;
                    occ_reg               <= occ_reg + 2'd1;
                end
                2'b01: begin
                    entry_reg[0] <= entry_reg[1];
                    occ_reg      <= occ_reg - 2'd1;
                end
                2'b11: begin
                    // Shift and refill together so FIFO order is preserved.
                    if (occ_reg == 2'd1) begin
                        entry_reg[0] <= push_data;
                    end else begin
                        entry_reg[0] <= entry_reg[1];
                        entry_reg[1] <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = entry_reg[0];
    assign occ  = occ_reg;

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts the simple_fifo pop interface into a valid/ready stream.
// Optional FIFO_RD_STREAM_STATS_EN adds saturating beat/stall counters.
module fifo_rd_stream import fifo_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int OBUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rddata,
    input  logic                  fifo_data_valid,
    output logic                  fifo_rden,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic                  protocol_err
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [31:0]           beat_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    if (OBUF_DEPTH != 2) begin : g_bad_depth
        $error("fifo_rd_stream: OBUF_DEPTH must be 2");
    end

    occ_t       occ;
    logic       pop;
    logic       push;
    logic       inflight_reg;
    logic       discard_reg;
    logic       discard;
    logic       unexpected;
    logic       overflow;
    logic       err_reg;
    logic [2:0] demand;

    assign pop     = m_valid && m_ready;
    assign m_valid = (occ != '0);

    // Words already owned or on the way, after this cycle's handshake.
    assign demand    = {1'b0, occ} + {2'b00, inflight_reg} - {2'b00, pop};
    assign fifo_rden = rst_n && !flush && !fifo_empty && (demand < 3'd2);

    // The word requested before a flush lands in the flush cycle; the cycle
    // after is also swallowed so a late stray word cannot leak out.
    assign discard    = flush || discard_reg;
    assign unexpected = fifo_data_valid && !inflight_reg;
    assign overflow   = fifo_data_valid && inflight_reg && !pop
                        && (occ == OCC_W'(OBUF_DEPTH));
    assign push       = fifo_data_valid && !discard && !unexpected && !overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_reg <= 1'b0;
            discard_reg  <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            inflight_reg <= fifo_rden;
            discard_reg  <= flush;
            if (!discard && (unexpected || overflow)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign protocol_err = err_reg;

    fifo_rd_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (fifo_rddata),
        .pop       (pop),
        .clear     (flush),
        .head      (m_data),
        .occ       (occ)
    );

`ifdef FIFO_RD_STREAM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop && (beat_cnt != '1)) begin
                beat_cnt <= beat_cnt + 32'd1;
            end
            if (m_valid && !m_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT,
// every issued word is expected on the stream in order unless flushed.
module tb_fifo_rd_stream;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rddata = '0;
    logic          fifo_data_valid = 1'b0;
    logic          fifo_rden;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          flush = 1'b0;
    logic          protocol_err;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0]   beat_cnt;
    logic [31:0]   stall_cnt;
`endif

    fifo_rd_stream #(.DATA_WIDTH(DW), .OBUF_DEPTH(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fifo_empty      (fifo_empty),
        .fifo_rddata     (fifo_rddata),
        .fifo_data_valid (fifo_data_valid),
        .fifo_rden       (fifo_rden),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .flush           (flush),
        .protocol_err    (protocol_err)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .beat_cnt        (beat_cnt),
        .stall_cnt       (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic          pend = 1'b0;
    logic [DW-1:0] pend_data = '0;
    logic          inject = 1'b0;
    int            delivered = 0;
    int            hs_total = 0;
    int            stall_total = 0;
    int            rden_pulses = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (bound expired or illegal event)", name);
    endtask

    // FIFO model: a pop is committed when rden is seen, data returns next cycle.
    always @(negedge clk) begin
        if (rst_n && fifo_rden) begin
            rden_pulses++;
            if (fifo_q.size() == 0) begin
                fail_now("fifo_underflow");
            end else begin
                pend_data = fifo_q.pop_front();
                exp_q.push_back(pend_data);
                pend = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        fifo_data_valid = pend | inject;
        fifo_rddata     = pend ? pend_data : 8'hEE;
        pend            = 1'b0;
        inject          = 1'b0;
        fifo_empty      = (fifo_q.size() == 0);
    end

    // Monitor: compare every handshake against the scoreboard queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready) begin
                hs_total++;
                delivered++;
                if (exp_q.size() == 0) fail_now("unexpected_beat");
                else check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
                $display("beat %0d data=0x%02h", delivered, m_data);
            end
            if (m_valid && !m_ready) stall_total++;
            prev_stall = m_valid && !m_ready && !flush;
            prev_data  = m_data;
            if (flush) exp_q.delete();
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        inject  = 1'b0;
        pend    = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        fifo_empty      = 1'b1;
        fifo_data_valid = 1'b0;
        delivered   = 0;
        hs_total    = 0;
        stall_total = 0;
        rden_pulses = 0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(DW'(i));
    endtask

    // mode 0: hold m_ready, 1: toggle, 2: random ready, 3: random ready + flush
    task automatic drain(input int mode, input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || m_valid) && n < budget) begin
            case (mode)
                1: m_ready = ~m_ready;
                2: m_ready = 1'($urandom_range(0, 1));
                3: begin
                    m_ready = 1'($urandom_range(0, 1));
                    flush   = ($urandom_range(0, 15) == 0);
                end
                default: ;
            endcase
            step(1);
            n++;
        end
        flush = 1'b0;
        if (n >= budget) fail_now(name);
    endtask

    task automatic check_stats();
`ifdef FIFO_RD_STREAM_STATS_EN
        check("beat_cnt", beat_cnt, 32'(hs_total));
        check("stall_cnt", stall_cnt, 32'(stall_total));
`endif
    endtask

    initial begin
        int t;
        int n;

        // Idle after reset with an empty FIFO.
        do_reset();
        repeat (20) begin
            @(negedge clk);
            check("idle_rden", 32'(fifo_rden), 32'd0);
            check("idle_valid", 32'(m_valid), 32'd0);
            check("idle_err", 32'(protocol_err), 32'd0);
        end

        // Full-throughput stream.
        step(1);
        m_ready = 1'b1;
        preload(32);
        n = 0;
        do begin @(negedge clk); n++; end while (!fifo_rden && n < 10);
        if (!fifo_rden) fail_now("first_rden");
        t = 0;
        do begin @(negedge clk); t++; end while (!m_valid && t < 10);
        check("fill_latency", 32'(t), 32'd2);
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            check("no_gap", 32'(m_valid), 32'd1);
        end
        step(1);
        drain(0, 100, "drain_stream");
        check("delivered_stream", 32'(delivered), 32'd32);
        check("err_stream", 32'(protocol_err), 32'd0);
        check_stats();

        // Stalled consumer: buffer fills to two, then resumes.
        do_reset();
        preload(32);
        step(12);
        check("stall_rden_pulses", 32'(rden_pulses), 32'd2);
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'h00);
        m_ready = 1'b1;
        drain(0, 100, "drain_stall");
        check("delivered_stall", 32'(delivered), 32'd32);
        check_stats();

        // Toggling then random ready.
        do_reset();
        preload(32);
        drain(1, 300, "drain_toggle");
        check("delivered_toggle", 32'(delivered), 32'd32);
        check_stats();
        do_reset();
        preload(32);
        drain(2, 500, "drain_random");
        check("delivered_random", 32'(delivered), 32'd32);
        check("err_random", 32'(protocol_err), 32'd0);
        check_stats();

        // Flush with one word buffered and one in flight.
        do_reset();
        preload(32);
        n = 0;
        while (!m_valid && n < 10) begin step(1); n++; end
        if (!m_valid) fail_now("flush_setup");
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        @(negedge clk);
        check("flush_valid", 32'(m_valid), 32'd0);
        check("flush_err", 32'(protocol_err), 32'd0);
        step(1);
        m_ready = 1'b1;
        drain(0, 100, "drain_flush");
        check("delivered_flush", 32'(delivered), 32'd30);
        check("flush_err_after", 32'(protocol_err), 32'd0);

        // Flush with a full buffer, then random flushes.
        do_reset();
        preload(32);
        step(8);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        @(negedge clk);
        check("flush_full_valid", 32'(m_valid), 32'd0);
        step(1);
        preload(16);
        drain(3, 800, "drain_rand_flush");
        check("rand_flush_err", 32'(protocol_err), 32'd0);
        check_stats();

        // Asynchronous reset mid-transfer.
        do_reset();
        preload(32);
        step(6);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(m_valid), 32'd0);
        check("async_rst_rden", 32'(fifo_rden), 32'd0);
        check("async_rst_data", 32'(m_data), 32'd0);

        // Unexpected data: sticky error, word dropped.
        do_reset();
        step(2);
        inject = 1'b1;
        step(3);
        @(negedge clk);
        check("proto_err_set", 32'(protocol_err), 32'd1);
        check("proto_occ", 32'(m_valid), 32'd0);
        step(5);
        check("proto_err_sticky", 32'(protocol_err), 32'd1);
        do_reset();
        @(negedge clk);
        check("proto_err_cleared", 32'(protocol_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
